// File: rtl/console_pkg.sv
// rtl/console_pkg.sv - shared types and constants for the console UART transmitter
package console_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int UART_DATA_BITS   = 8;
    localparam int DEFAULT_BAUD_DIV = 868;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/console_uart_tx_if.sv
// rtl/console_uart_tx_if.sv - byte handshake between the Wrapper console port and the UART
interface console_uart_tx_if;
    import console_pkg::*;

    logic [UART_DATA_BITS-1:0] CONSOLE_OUT;
    logic                      CONSOLE_OUT_valid;
    logic                      CONSOLE_OUT_ready;

    modport master (
        output CONSOLE_OUT,
        output CONSOLE_OUT_valid,
        input  CONSOLE_OUT_ready
    );

    modport slave (
        input  CONSOLE_OUT,
        input  CONSOLE_OUT_valid,
        output CONSOLE_OUT_ready
    );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock circular FIFO with occupancy count
module sync_fifo
    import console_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int CNT_W = clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/console_uart_tx.sv
// rtl/console_uart_tx.sv - buffers console bytes and sends them as 8N1 UART frames
module console_uart_tx
    import console_pkg::*;
#(
    parameter int BAUD_DIV   = DEFAULT_BAUD_DIV,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 5
) (
    input  logic              CLK,
    input  logic              RESET,
    console_uart_tx_if.slave  console,
    output logic              TX,
    output logic              BUSY,
    output logic [CNT_W-1:0]  FIFO_COUNT
);
    localparam int BW = clog2(BAUD_DIV);

    uart_state_t               state_q, state_d;
    logic [BW-1:0]             cnt_q, cnt_d;
    logic [2:0]                bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      tx_d;
    logic                      tick;
    logic                      pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [UART_DATA_BITS-1:0] fifo_rdata;

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RESET),
        .push  (console.CONSOLE_OUT_valid && console.CONSOLE_OUT_ready),
        .wdata (console.CONSOLE_OUT),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (FIFO_COUNT)
    );

    assign console.CONSOLE_OUT_ready = !RESET && !fifo_full;
    assign BUSY = (state_q != IDLE) || (FIFO_COUNT != '0);
    assign tick = (cnt_q == BW'(BAUD_DIV - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rdata;
                    state_d = START;
                end
            end
            START: begin
                cnt_d = cnt_q + 1'b1;
                if (tick) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                cnt_d = cnt_q + 1'b1;
                if (tick) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'(UART_DATA_BITS - 1)) state_d = STOP;
                    else                                 bit_d   = bit_q + 1'b1;
                end
            end
            STOP: begin
                cnt_d = cnt_q + 1'b1;
                if (tick) begin
                    cnt_d = '0;
                    // Chain straight into the next start bit when more data is waiting.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_rdata;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // TX is registered from the next state so the line changes on the same edge as the FSM.
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            TX      <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            TX      <= tx_d;
        end
    end

endmodule
